// File: rtl/seq_executor_pkg.sv
// Widths, limits and the sequence legality rule for the LZ77 sequence executor.
`include "parameters.vh"

package seq_executor_pkg;

  localparam int LL_W              = `SEQ_LL_BITS;
  localparam int ML_W              = `SEQ_ML_BITS;
  localparam int OFF_W             = `SEQ_OFFSET_BITS;
  localparam int unsigned MIN_MATCH = `MIN_MATCH_LEN;
  localparam int HIST_ADDR_BITS_DEF = `HIST_ADDR_BITS_DEFAULT;

  // A match must be long enough, point backwards, and stay inside both the
  // window and the bytes actually produced since reset.
  function automatic logic seq_illegal(input logic             delim,
                                       input logic [ML_W-1:0]  ml,
                                       input logic [OFF_W-1:0] off,
                                       input int unsigned      produced,
                                       input int unsigned      depth);
    logic has_match;
    has_match = (ml != '0);
    return (delim && has_match) ||
           (has_match && ((32'(ml) < MIN_MATCH) ||
                          (off == '0) ||
                          (32'(off) > depth) ||
                          (32'(off) > produced)));
  endfunction

endpackage

// File: rtl/parameters.vh
// Shared stream field widths for the sequence serializer / literal packer / executor chain.
`ifndef PARAMETERS_VH
`define PARAMETERS_VH
`define SEQ_LL_BITS 16
`define SEQ_ML_BITS 16
`define SEQ_OFFSET_BITS 17
`define MIN_MATCH_LEN 3
`define HIST_ADDR_BITS_DEFAULT 12
`endif

// File: rtl/seq_executor_history_buf.sv
// Circular history window: one synchronous write port, one asynchronous read port.
module seq_history_buf #(
  parameter int ADDR_BITS = 12
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] waddr_i,
  input  logic [7:0]           wdata_i,
  input  logic [ADDR_BITS-1:0] raddr_i,
  output logic [7:0]           rdata_o
);

  logic [7:0] mem_q [1 << ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/seq_executor.sv
// Executes (ll, ml, offset, delim) sequences against a literal byte stream and
// rebuilds the original data one byte per cycle.
//
// Handshakes: a beat transfers on a clock edge where valid & ready are both
// high; a source never drops valid or changes data while waiting for ready.
module seq_executor
  import seq_executor_pkg::*;
#(
  parameter int HIST_ADDR_BITS = HIST_ADDR_BITS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [LL_W-1:0]  i_ll,
  input  logic [ML_W-1:0]  i_ml,
  input  logic [OFF_W-1:0] i_offset,
  input  logic             i_delim,
  output logic             i_ready,
  input  logic             lit_valid,
  input  logic [7:0]       lit_data,
  output logic             lit_ready,
  output logic             o_valid,
  output logic [7:0]       o_data,
  output logic             o_empty,
  output logic             o_last,
  input  logic             o_ready,
  output logic             o_err,
  output logic [2:0]       dbg_state_o
);

  localparam int HB = HIST_ADDR_BITS;
  localparam int unsigned DEPTH = 1 << HB;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LIT   = 3'd1,
    S_COPY  = 3'd2,
    S_DELIM = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [LL_W-1:0] ll_q, ll_d;
  logic [ML_W-1:0] ml_q, ml_d;
  logic [HB-1:0]   off_q, off_d;
  logic            delim_q, delim_d;
  logic [HB-1:0]   wptr_q, wptr_d;
  logic [HB:0]     prod_q, prod_d;

  logic          hist_we;
  logic [7:0]    hist_wdata;
  logic [7:0]    hist_rdata;
  logic [HB-1:0] hist_raddr;

  // An offset of exactly DEPTH has zero low bits and reads the slot about to
  // be overwritten, which is the byte DEPTH positions back.
  assign hist_raddr = wptr_q - off_q;

  seq_history_buf #(
    .ADDR_BITS(HB)
  ) u_hist (
    .clk     (clk),
    .we_i    (hist_we && !rst),
    .waddr_i (wptr_q),
    .wdata_i (hist_wdata),
    .raddr_i (hist_raddr),
    .rdata_o (hist_rdata)
  );

  always_comb begin
    state_d    = state_q;
    ll_d       = ll_q;
    ml_d       = ml_q;
    off_d      = off_q;
    delim_d    = delim_q;
    wptr_d     = wptr_q;
    prod_d     = prod_q;
    i_ready    = 1'b0;
    lit_ready  = 1'b0;
    o_valid    = 1'b0;
    o_data     = 8'h00;
    o_empty    = 1'b0;
    o_last     = 1'b0;
    o_err      = 1'b0;
    hist_we    = 1'b0;
    hist_wdata = 8'h00;

    case (state_q)
      S_IDLE: begin
        i_ready = !rst;
        if (i_valid) begin
          ll_d    = i_ll;
          ml_d    = i_ml;
          off_d   = i_offset[HB-1:0];
          delim_d = i_delim;
          if (seq_illegal(i_delim, i_ml, i_offset, 32'(prod_q), DEPTH)) begin
            state_d = S_ERR;
          end else if (i_ll != '0) begin
            state_d = S_LIT;
          end else if (i_ml != '0) begin
            state_d = S_COPY;
          end else if (i_delim) begin
            state_d = S_DELIM;
          end
        end
      end

      S_LIT: begin
        o_valid   = lit_valid;
        lit_ready = o_ready;
        o_data    = lit_data;
        o_last    = delim_q && (ll_q == LL_W'(1));
        if (lit_valid && o_ready) begin
          hist_we    = 1'b1;
          hist_wdata = lit_data;
          ll_d       = ll_q - LL_W'(1);
          if (ll_q == LL_W'(1)) begin
            state_d = (ml_q != '0) ? S_COPY : S_IDLE;
          end
        end
      end

      S_COPY: begin
        o_valid = 1'b1;
        o_data  = hist_rdata;
        if (o_ready) begin
          hist_we    = 1'b1;
          hist_wdata = hist_rdata;
          ml_d       = ml_q - ML_W'(1);
          if (ml_q == ML_W'(1)) begin
            state_d = S_IDLE;
          end
        end
      end

      S_DELIM: begin
        o_valid = 1'b1;
        o_empty = 1'b1;
        o_last  = 1'b1;
        if (o_ready) begin
          state_d = S_IDLE;
        end
      end

      S_ERR: begin
        o_err = 1'b1;
      end

      default: begin
        state_d = S_ERR;
      end
    endcase

    if (hist_we) begin
      wptr_d = wptr_q + HB'(1);
      prod_d = (32'(prod_q) == DEPTH) ? prod_q : prod_q + (HB + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ll_q    <= '0;
      ml_q    <= '0;
      off_q   <= '0;
      delim_q <= 1'b0;
      wptr_q  <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      ll_q    <= ll_d;
      ml_q    <= ml_d;
      off_q   <= off_d;
      delim_q <= delim_d;
      wptr_q  <= wptr_d;
      prod_q  <= prod_d;
    end
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seq_executor.sv
// Randomized and directed bench for seq_executor against a byte-level model of
// LZ77 reconstruction (output history as a plain byte queue).
module tb_seq_executor;
  import seq_executor_pkg::*;

  localparam int HB    = HIST_ADDR_BITS_DEF;
  localparam int DEPTH = 1 << HB;

  logic             clk;
  logic             rst;
  logic             i_valid;
  logic [LL_W-1:0]  i_ll;
  logic [ML_W-1:0]  i_ml;
  logic [OFF_W-1:0] i_offset;
  logic             i_delim;
  logic             i_ready;
  logic             lit_valid;
  logic [7:0]       lit_data;
  logic             lit_ready;
  logic             o_valid;
  logic [7:0]       o_data;
  logic             o_empty;
  logic             o_last;
  logic             o_ready;
  logic             o_err;
  logic [2:0]       dbg_state;

  seq_executor dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .i_ll       (i_ll),
    .i_ml       (i_ml),
    .i_offset   (i_offset),
    .i_delim    (i_delim),
    .i_ready    (i_ready),
    .lit_valid  (lit_valid),
    .lit_data   (lit_data),
    .lit_ready  (lit_ready),
    .o_valid    (o_valid),
    .o_data     (o_data),
    .o_empty    (o_empty),
    .o_last     (o_last),
    .o_ready    (o_ready),
    .o_err      (o_err),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [9:0] exp_q[$];      // {empty, last, data}
  logic [7:0] lit_q[$];      // literal bytes still to be offered
  logic [7:0] hist_m[$];     // every byte produced since reset
  logic [7:0] preset_q[$];   // directed literal values, else random
  bit         ready_rand = 0;
  bit         lit_gaps   = 0;
  bit         hs_lit     = 0;
  bit         hold_v     = 0;
  logic [9:0] hold_b     = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- background drivers / monitor ----------------
  always @(posedge clk) begin
    #2;
    o_ready = ready_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  always @(posedge clk) begin
    #2;
    if (rst) begin
      lit_valid = 1'b0;
    end else begin
      if (hs_lit) begin
        if (lit_q.size() > 0) void'(lit_q.pop_front());
        lit_valid = 1'b0;
      end
      if (!lit_valid && lit_q.size() > 0 && (!lit_gaps || $urandom_range(0, 2) != 0)) begin
        lit_valid = 1'b1;
        lit_data  = lit_q[0];
      end
    end
  end

  always @(negedge clk) begin
    logic [9:0] beat;
    hs_lit = lit_valid && lit_ready && !rst;
    if (rst) begin
      hold_v = 0;
    end else if (o_valid) begin
      beat = {o_empty, o_last, o_data};
      if (hold_v) check("stall_stable", beat, hold_b);
      if (o_ready) begin
        if (exp_q.size() == 0) check("extra_beat", exp_q.size(), 1);
        else check("beat", beat, exp_q.pop_front());
        hold_v = 0;
      end else begin
        hold_v = 1;
        hold_b = beat;
      end
    end else if (hold_v) begin
      check("stall_drop", o_valid, 1);
      hold_v = 0;
    end
  end

  // ---------------- reference model + driver tasks ----------------
  function automatic int produced_m();
    return (hist_m.size() > DEPTH) ? DEPTH : hist_m.size();
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    i_valid = 1'b0;
    exp_q.delete(); lit_q.delete(); hist_m.delete(); preset_q.delete();
    @(negedge clk);
    check("rst_i_ready", i_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_i_ready", i_ready, 1);
    check("post_rst_o_valid", o_valid, 0);
    check("post_rst_lit_ready", lit_ready, 0);
    check("post_rst_o_err", o_err, 0);
  endtask

  task automatic push_preset(input string s);
    for (int i = 0; i < s.len(); i++) preset_q.push_back(s[i]);
  endtask

  task automatic send_seq(input int ll, input int ml, input int off, input bit delim, output bit err);
    logic [7:0] b;
    bit         lastb;
    bit         ok;
    err = (delim && ml != 0) ||
          (ml != 0 && (ml < int'(MIN_MATCH) || off == 0 || off > DEPTH || off > produced_m()));
    if (!err) begin
      for (int i = 0; i < ll; i++) begin
        b = (preset_q.size() > 0) ? preset_q.pop_front() : 8'($urandom_range(0, 255));
        lastb = delim && (i == ll - 1);
        lit_q.push_back(b);
        hist_m.push_back(b);
        exp_q.push_back({1'b0, lastb, b});
      end
      for (int k = 0; k < ml; k++) begin
        b = hist_m[hist_m.size() - off];
        hist_m.push_back(b);
        exp_q.push_back({2'b00, b});
      end
      if (ll == 0 && ml == 0 && delim) exp_q.push_back(10'h300);
    end
    @(posedge clk); #1;
    i_valid  = 1'b1;
    i_ll     = LL_W'(ll);
    i_ml     = ML_W'(ml);
    i_offset = OFF_W'(off);
    i_delim  = delim;
    ok = 0;
    for (int c = 0; c < 20000 && !ok; c++) begin
      @(negedge clk);
      ok = i_ready;
    end
    if (!ok) check("tmo_accept", ok, 1);
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    bit done = 0;
    for (int c = 0; c < 30000 && !done; c++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && i_ready && !o_valid;
    end
    check({tag, "_drained"}, done, 1);
    check({tag, "_no_err"}, o_err, 0);
  endtask

  task automatic expect_err(input string tag);
    @(negedge clk);
    check({tag, "_o_err"}, o_err, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check({tag, "_i_ready_low"}, i_ready, 0);
      check({tag, "_o_valid_low"}, o_valid, 0);
      check({tag, "_lit_ready_low"}, lit_ready, 0);
    end
    do_reset();
  endtask

  task automatic run(input string tag, input int ll, input int ml, input int off, input bit delim);
    bit e;
    send_seq(ll, ml, off, delim, e);
    if (e) expect_err(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit e;
    rst = 1'b1; i_valid = 1'b0; i_ll = '0; i_ml = '0; i_offset = '0; i_delim = 1'b0;
    lit_valid = 1'b0; lit_data = '0; o_ready = 1'b1;
    do_reset();

    // literals only; first beat one cycle after accept, then back to back
    push_preset("ABCDE");
    send_seq(5, 0, 0, 0, e);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("lit_back_to_back", o_valid, 1);
    end
    wait_drain("literals");

    // overlapping copies
    push_preset("x");
    run("ovl1", 1, 6, 1, 0);
    push_preset("ab");
    run("ovl2", 2, 4, 2, 0);
    wait_drain("overlap");

    // delimiters with and without literals
    push_preset("pqr");
    run("delim_lit", 3, 0, 0, 1);
    run("delim_empty", 0, 0, 0, 1);
    run("empty_seq", 0, 0, 0, 0);
    wait_drain("delims");

    // backpressure and literal gaps
    ready_rand = 1; lit_gaps = 1;
    run("bp", 2, 4, 2, 0);
    wait_drain("backpressure");

    // random legal sequences
    for (int n = 0; n < 150; n++) begin
      int ll, ml, off, lim;
      bit dl;
      ready_rand = ($urandom_range(0, 1) == 1);
      lit_gaps   = ($urandom_range(0, 1) == 1);
      ll = $urandom_range(0, 6);
      ml = (produced_m() == 0 || $urandom_range(0, 3) == 0) ? 0 : $urandom_range(3, 10);
      lim = (produced_m() < 64) ? produced_m() : 64;
      off = (ml == 0) ? 0 : $urandom_range(1, lim);
      dl  = (ml == 0) && ($urandom_range(0, 4) == 0);
      run("rand", ll, ml, off, dl);
    end
    wait_drain("random");
    ready_rand = 0; lit_gaps = 0;

    // error rules, each with the boundary just inside first
    do_reset();
    run("pre3", 3, 0, 0, 0);
    wait_drain("pre3");
    run("off_eq_prod", 0, 4, 3, 0);
    wait_drain("off_eq_prod");
    run("off_gt_prod", 0, 4, 8, 0);
    run("pre3b", 3, 0, 0, 0);
    wait_drain("pre3b");
    run("off_gt_prod3", 0, 4, 5, 0);
    run("pre3c", 3, 0, 0, 0);
    wait_drain("pre3c");
    run("delim_with_ml", 1, 4, 2, 1);
    run("pre3d", 3, 0, 0, 0);
    wait_drain("pre3d");
    run("off_zero", 0, 4, 0, 0);
    run("pre3e", 3, 0, 0, 0);
    wait_drain("pre3e");
    run("ml_short", 0, 2, 1, 0);

    // window wrap: copy from exactly one window back
    run("fill", 5000, 0, 0, 0);
    run("wrap_copy", 0, 8, 4096, 0);
    wait_drain("wrap");
    run("off_gt_window", 0, 4, 4097, 0);

    // reset in the middle of a copy clears the produced count
    run("fill2", 4, 0, 0, 0);
    run("long_copy", 0, 200, 1, 0);
    repeat (10) @(negedge clk);
    do_reset();
    run("no_history", 0, 4, 1, 0);

    check("lit_leftover", lit_q.size(), 0);
    check("exp_leftover", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
